// File: rtl/jt08_adpcm_rom_rd.sv
// ADPCM-A ROM read responder: per-channel one-byte cache in front of a req/ok ROM port.
// Optional JT08_ADPCM_ROM_RD_STATS_EN adds saturating hit/late counters.
module jt08_adpcm_rom_rd #(
    parameter int TOUT = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [5:0]  cur_ch,
    input  logic [19:0] addr,
    input  logic        sel,
    input  logic        roe_n,
    input  logic        clr,
    output logic [19:0] rom_addr,
    output logic        rom_cs,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok,
`ifdef JT08_ADPCM_ROM_RD_STATS_EN
    output logic [7:0]  hit_cnt,
    output logic [7:0]  miss_cnt,
`endif
    output logic [3:0]  data,
    output logic        data_ok,
    output logic        late
);

    localparam int CW = $clog2(TOUT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] tout_q;
    logic [5:0]    valid_q;
    logic [19:0]   tag_q   [6];
    logic [7:0]    cbyte_q [6];

    logic [19:0]   req_addr_q;
    logic          req_sel_q;
    logic          req_pend_q;
    logic          req_cache_q;
    logic [2:0]    req_idx_q;
    logic [7:0]    byte_q;
    logic          res_ok_q;

    logic [2:0]    ch_idx;
    logic          onehot;
    logic          hit;
    logic          fetch_ok;

    always_comb begin
        ch_idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (cur_ch[i]) ch_idx = 3'(i);
        end
    end

    assign onehot = (cur_ch != 6'd0) && ((cur_ch & (cur_ch - 6'd1)) == 6'd0);
    // A coinciding clr invalidates before lookup, so it can never hit
    assign hit      = onehot && !clr && valid_q[ch_idx] && (tag_q[ch_idx] == addr);
    // rom_ok on the delivery edge is too late: the abort wins
    assign fetch_ok = (state_q == FETCH) && !cen && rom_ok;

    always_ff @(posedge clk) begin
        if (fetch_ok && req_cache_q) begin
            tag_q[req_idx_q]   <= req_addr_q;
            cbyte_q[req_idx_q] <= rom_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tout_q      <= '0;
            valid_q     <= '0;
            req_addr_q  <= '0;
            req_sel_q   <= 1'b0;
            req_pend_q  <= 1'b0;
            req_cache_q <= 1'b0;
            req_idx_q   <= 3'd0;
            byte_q      <= 8'd0;
            res_ok_q    <= 1'b0;
            rom_addr    <= '0;
            rom_cs      <= 1'b0;
            data        <= 4'd0;
            data_ok     <= 1'b0;
            late        <= 1'b0;
`ifdef JT08_ADPCM_ROM_RD_STATS_EN
            hit_cnt     <= 8'd0;
            miss_cnt    <= 8'd0;
`endif
        end else begin
            late <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (fetch_ok) begin
                        byte_q   <= rom_data;
                        res_ok_q <= 1'b1;
                        rom_cs   <= 1'b0;
                        state_q  <= DONE;
                        if (req_cache_q) valid_q[req_idx_q] <= 1'b1;
                    end else if (!cen) begin
                        if (tout_q == CW'(TOUT - 1)) begin
                            rom_cs  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            tout_q <= tout_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (cen) begin
                if (req_pend_q) begin
                    if (res_ok_q) begin
                        data    <= req_sel_q ? byte_q[3:0] : byte_q[7:4];
                        data_ok <= 1'b1;
                    end else begin
                        data    <= 4'd0;
                        data_ok <= 1'b0;
                        late    <= 1'b1;
`ifdef JT08_ADPCM_ROM_RD_STATS_EN
                        if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
`endif
                    end
                end else begin
                    data_ok <= 1'b0;
                end

                rom_cs  <= 1'b0;
                state_q <= IDLE;
                if (clr && onehot) valid_q[ch_idx] <= 1'b0;

                req_pend_q <= !roe_n;
                if (!roe_n) begin
                    req_addr_q  <= addr;
                    req_sel_q   <= sel;
                    req_cache_q <= onehot;
                    req_idx_q   <= ch_idx;
                    if (hit) begin
                        byte_q   <= cbyte_q[ch_idx];
                        res_ok_q <= 1'b1;
`ifdef JT08_ADPCM_ROM_RD_STATS_EN
                        if (hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
`endif
                    end else begin
                        res_ok_q <= 1'b0;
                        tout_q   <= '0;
                        rom_addr <= addr;
                        rom_cs   <= 1'b1;
                        state_q  <= FETCH;
                    end
                end
            end
        end
    end

endmodule

// File: doc/jt08_adpcm_rom_rd.md
Name: jt08_adpcm_rom_rd

Overview:
- ROM-side responder for the ADPCM-A address counter.
- Each cen slot it accepts a nibble read request (byte address, nibble select, active-low read strobe) and fetches the byte from external ROM/SDRAM through a req/ok handshake.
- Delivers the selected nibble to the ADPCM decoder at the next cen.
- Keeps a one-byte cache per channel, so the second nibble of a byte needs no ROM access.

Parameters:
- TOUT, 24: max clk cycles a fetch may wait for rom_ok before it is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cen  in  1  ADPCM slot enable (666 kHz)
- cur_ch  in  6  one-hot channel owning the current slot
- addr  in  20  byte address from the counter
- sel  in  1  nibble select: 0 = data[7:4], 1 = data[3:0]
- roe_n  in  1  read request, active low, sampled on cen
- clr  in  1  channel restart; invalidates that channel's cache entry
- rom_addr  out  20  address to ROM
- rom_cs  out  1  ROM request, held until rom_ok or abort
- rom_data  in  8  ROM read data
- rom_ok  in  1  rom_data valid for rom_addr while rom_cs high
- data  out  4  nibble to decoder
- data_ok  out  1  data valid for the current slot
- late  out  1  one-clk pulse when a fetch missed its deadline

Behaviour:
- Reset values:
  - rom_addr=0, rom_cs=0, data=0, data_ok=0, late=0
  - all six cache entries invalid; FSM=IDLE; timeout counter=0
- Request capture (cen high):
  - roe_n=0 latches addr, sel and cur_ch into the request registers.
  - roe_n=1 leaves no request pending.
- Channel index = position of the single set bit of cur_ch.
  - Zero or multiple bits set: the request is uncacheable. It is always fetched and never written to the cache.
- clr on cen with a valid one-hot cur_ch clears that entry's valid bit.
  - If clr and a request coincide, the invalidation happens first, so the request misses.
- Hit (entry valid, tag==addr): byte taken from cache; FSM stays IDLE; rom_cs stays 0.
- Miss: FSM goes to FETCH.
  - rom_addr=addr and rom_cs=1 on the clk after cen.
  - On rom_cs && rom_ok: capture rom_data, write cache entry (tag=addr, valid=1), rom_cs=0, FSM→DONE.
- FETCH timeout: the counter increments each clk. At TOUT the FSM→IDLE, rom_cs=0 and the result is marked failed.
- Delivery at the next cen:
  - Hit or DONE: data = sel ? byte[3:0] : byte[7:4], data_ok=1.
  - FETCH still pending or failed: data=0, data_ok=0, late=1 for one clk. Any pending fetch is aborted (rom_cs=0).
  - No request in the previous slot: data_ok=0, data keeps its last value.
- data and data_ok are stable between cens.
- Overlap: a new request captured on the same cen that delivers (or aborts) the previous one is processed normally. The delivery registers use the old result.
- rom_ok while rom_cs=0 is ignored.
- rom_addr holds its value after rom_cs drops.
- Reset mid-fetch drops rom_cs immediately, invalidates all entries and returns the FSM to IDLE.
- Latency:
  - hit → data on the next cen;
  - miss → data on the next cen only if rom_ok arrives at least 1 clk before it.

Optional Feature:
JT08_ADPCM_ROM_RD_STATS_EN
- Defined: adds outputs hit_cnt[7:0] and miss_cnt[7:0].
  - Both are saturating counters, reset to 0.
  - hit_cnt increments per cache hit.
  - miss_cnt increments per late pulse.
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- Reset with rst=1 mid-fetch (rom_cs=1) → rom_cs=0 asynchronously, data_ok=0, late=0; next request at same address misses.
- Miss: cen, roe_n=0, addr=0x001C0, sel=0, cur_ch=6'b000010, rom_ok with rom_data=0xA7 three clks later → rom_addr=0x001C0, rom_cs high 3 clks; next cen data=0xA, data_ok=1.
- Hit: following slot for channel 1, addr=0x001C0, sel=1 → rom_cs stays 0; next cen data=0x7, data_ok=1.
- Invalidate: clr=1 with roe_n=0, cur_ch=6'b000010, addr=0x001C0 → rom_cs asserted (refetch), cache rewritten with new rom_data.
- Deadline: miss with rom_ok never asserted and cen period below TOUT → rom_cs drops at the next cen, data=0, data_ok=0, late pulses once.
- Timeout: miss with cen period 40 clks, TOUT=24, no rom_ok → rom_cs drops after 24 clks; next cen data_ok=0, late=1.
